dma_controller: RTL and testbench
=================================

# dma_controller

Single-channel DMA engine that moves 32-bit words between the disk and the DRAM over the shared `dataBus` without CPU involvement. The CPU programs source address, destination address, word count and direction, then sets start. The block requests the bus with HOLD/HLDA and drives the DRAM strobes (`MEMR`/`MEMW`, `addressBus_DRAM`) and disk strobes (`IOR`/`IOW`, `addressBus_disk`). It raises `done` when the transfer completes. It sits directly upstream of the DRAM.

## Interface
- `ADDR_W`, default 10: word-address width, shared by disk and DRAM.
- `DATA_W`, default 32: data bus width.
- `CLK`  in  1  system clock; all state changes on rising edge.
- `RST_n`  in  1  asynchronous, active-low reset.
- `cfg_we`  in  1  CPU register write strobe, sampled on `CLK`.
- `cfg_addr`  in  2  register select: 0 = SRC, 1 = DST, 2 = COUNT, 3 = CTRL (bit0 start, bit1 dir).
- `cfg_wdata`  in  DATA_W  register write data.
- `HOLD`  out  1  bus request to the CPU.
- `HLDA`  in  1  bus grant from the CPU.
- `dataBus`  inout  DATA_W  shared data bus; the block drives it only in WR of a DRAM-to-disk or disk-to-DRAM write, otherwise high-Z.
- `addressBus_DRAM`  out  ADDR_W  DRAM word address.
- `MEMR`, `MEMW`  out  1 each  DRAM read and write strobes.
- `addressBus_disk`  out  ADDR_W  disk word address.
- `IOR`, `IOW`  out  1 each  disk read and write strobes.
- `busy`  out  1  high from accepted start until DONE exits.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Registers: SRC and DST are ADDR_W wide; COUNT is ADDR_W+1 bits (0..1024); DIR is 1 bit.
  - dir = 0: disk→DRAM. SRC is the disk address, DST is the DRAM address.
  - dir = 1: DRAM→disk. SRC is the DRAM address, DST is the disk address.
- `cfg_we` while `busy` = 1 is ignored, including CTRL.start.
- Start with COUNT = 0: no bus request. `done` pulses the next cycle; `busy` stays 0.
- FSM states:
  - IDLE: accepted start with COUNT ≠ 0 → REQ.
  - REQ: HOLD = 1; waits for HLDA = 1 → RD.
  - RD: read strobe of the source device asserted (IOR for dir 0, MEMR for dir 1) with the source address. `dataBus` is captured into the holding register at the end of the cycle → WR.
  - WR: the block drives `dataBus` = holding register and asserts the destination write strobe (MEMW for dir 0, IOW for dir 1) with the destination address. At the end of the cycle: SRC++, DST++, COUNT--.
  - WR exits: COUNT reaches 0 → DONE; HLDA = 0 → REQ (HOLD stays 1, resumes after re-grant); otherwise → RD.
  - DONE: HOLD = 0, `done` = 1 for one cycle → IDLE.
- Addresses wrap modulo 2^ADDR_W (1023 → 0). No error is flagged.
- A word in flight always completes RD+WR, even if HLDA falls mid-word.
- At most one strobe (IOR/IOW/MEMR/MEMW) is high in any cycle.

## Timing
- All outputs are registered.
- Reset values:
  - HOLD, MEMR, MEMW, IOR, IOW, busy, done = 0.
  - both address buses = 0.
  - `dataBus` = high-Z.
  - registers = 0; FSM = IDLE.
- Start written in cycle 0 → HOLD = 1 and busy = 1 in cycle 1.
- HLDA high in cycle n → RD in cycle n+1.
- Throughput: 2 cycles per word. N words take 2N cycles from the first RD to the last WR; DONE follows in the next cycle.
- Reset asserted mid-transfer forces all outputs to their reset values immediately (asynchronously), and the bus is released. The partial transfer is abandoned.

## Structure
- Package `dma_pkg`: state enum (IDLE, REQ, RD, WR, DONE), register offsets, CTRL bit positions, default ADDR_W/DATA_W.
- Sub-module `dma_cfg_regs`: SRC/DST/COUNT/DIR storage, write decode with busy lockout, increment/decrement ports. The FSM and bus drivers stay in the top.

## Test plan
- Disk words 5..7 = A, B, C; SRC = 5, DST = 100, COUNT = 3, dir = 0, HLDA 2 cycles after HOLD:
  - DRAM[100..102] = A, B, C.
  - 6 strobe cycles alternating IOR/MEMW.
  - `done` pulse; HOLD = 0 afterwards.
- DRAM[1022], DRAM[1023], DRAM[0] = X, Y, Z; SRC = 1022, DST = 0, COUNT = 3, dir = 1:
  - disk[0..2] = X, Y, Z.
  - `addressBus_DRAM` wraps 1023 → 0.
- COUNT = 0 with start → `done` pulses the next cycle; HOLD never rises; no strobes.
- HLDA dropped during the RD of word 2 of 4:
  - word 2 completes.
  - FSM parks in REQ with HOLD = 1 and no strobes.
  - after re-grant, words 3–4 transfer correctly.
- `RST_n` low during WR of word 1:
  - all strobes and HOLD = 0 immediately; `dataBus` = Z.
  - the next programmed transfer runs normally.
- Writing SRC while busy → the register is unchanged and the in-progress addresses are unaffected.

Source files
------------

// File: rtl/dma_pkg.sv
// dma_pkg: shared types and constants for the DMA engine
// register map, CTRL bit positions, FSM state encoding
package dma_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;

  localparam logic [1:0] REG_SRC   = 2'd0;
  localparam logic [1:0] REG_DST   = 2'd1;
  localparam logic [1:0] REG_COUNT = 2'd2;
  localparam logic [1:0] REG_CTRL  = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_DIR   = 1;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RD,
    WR,
    DONE
  } state_t;

endpackage

// File: rtl/dma_cfg_regs.sv
// dma_cfg_regs: CPU-visible SRC/DST/COUNT/DIR registers
// writes are locked out while a transfer is busy
module dma_cfg_regs
  import dma_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  input  logic              busy,
  input  logic              step,
  output logic [ADDR_W-1:0] src,
  output logic [ADDR_W-1:0] dst,
  output logic [ADDR_W:0]   count,
  output logic              dir,
  output logic              start
);

  logic wr_ok;
  logic unused_bits;

  assign wr_ok = cfg_we && !busy;
  assign start = wr_ok && (cfg_addr == REG_CTRL)
              && cfg_wdata[CTRL_START];
  assign unused_bits = ^cfg_wdata[DATA_W-1:ADDR_W+1];

  // register storage: per-word advance, else CPU write
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      src   <= '0;
      dst   <= '0;
      count <= '0;
      dir   <= 1'b0;
    end else if (step) begin
      src   <= src + 1'b1;
      dst   <= dst + 1'b1;
      count <= count - 1'b1;
    end else if (wr_ok) begin
      case (cfg_addr)
        REG_SRC:   src   <= cfg_wdata[ADDR_W-1:0];
        REG_DST:   dst   <= cfg_wdata[ADDR_W-1:0];
        REG_COUNT: count <= cfg_wdata[ADDR_W:0];
        REG_CTRL:  dir   <= cfg_wdata[CTRL_DIR];
        default:   dir   <= dir;
      endcase
    end
  end

endmodule

// File: rtl/dma_controller.sv
// dma_controller: single-channel disk<->DRAM DMA engine
// HOLD/HLDA bus ownership, registered strobes and addresses
module dma_controller
  import dma_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  output logic              HOLD,
  input  logic              HLDA,
  inout  wire  [DATA_W-1:0] dataBus,
  output logic [ADDR_W-1:0] addressBus_DRAM,
  output logic              MEMR,
  output logic              MEMW,
  output logic [ADDR_W-1:0] addressBus_disk,
  output logic              IOR,
  output logic              IOW,
  output logic              busy,
  output logic              done
);

  state_t state, nxt;

  logic [ADDR_W-1:0] src, dst, src_rd;
  logic [ADDR_W:0]   count;
  logic              dir, start, step;
  logic              last, zero_start, drive;
  logic [DATA_W-1:0] word;

  dma_cfg_regs #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_regs (
    .CLK      (CLK),
    .RST_n    (RST_n),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_wdata(cfg_wdata),
    .busy     (busy),
    .step     (step),
    .src      (src),
    .dst      (dst),
    .count    (count),
    .dir      (dir),
    .start    (start)
  );

  assign step       = (state == WR);
  assign last       = (count == {{ADDR_W{1'b0}}, 1'b1});
  assign zero_start = start && (count == '0);
  // next read address must see the increment taking effect now
  assign src_rd     = step ? src + 1'b1 : src;
  assign dataBus    = drive ? word : {DATA_W{1'bz}};

  // state register
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) state <= IDLE;
    else        state <= nxt;
  end

  // next-state decode; a started word always finishes RD+WR
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (start && count != '0) nxt = REQ;
      REQ:  if (HLDA) nxt = RD;
      RD:   nxt = WR;
      WR: begin
        if (last)       nxt = DONE;
        else if (!HLDA) nxt = REQ;
        else            nxt = RD;
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // outputs registered from the state being entered
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      HOLD            <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      IOR             <= 1'b0;
      IOW             <= 1'b0;
      MEMR            <= 1'b0;
      MEMW            <= 1'b0;
      drive           <= 1'b0;
      word            <= '0;
      addressBus_DRAM <= '0;
      addressBus_disk <= '0;
    end else begin
      HOLD  <= (nxt == REQ) || (nxt == RD) || (nxt == WR);
      busy  <= (nxt != IDLE);
      done  <= (nxt == DONE) || zero_start;
      IOR   <= (nxt == RD) && !dir;
      MEMR  <= (nxt == RD) && dir;
      MEMW  <= (nxt == WR) && !dir;
      IOW   <= (nxt == WR) && dir;
      drive <= (nxt == WR);
      if (state == RD) word <= dataBus;
      if (nxt == RD) begin
        if (dir) addressBus_DRAM <= src_rd;
        else     addressBus_disk <= src_rd;
      end
      if (nxt == WR) begin
        if (dir) addressBus_disk <= dst;
        else     addressBus_DRAM <= dst;
      end
    end
  end

endmodule

// File: tb/tb_dma_controller.sv
// tb_dma_controller: directed bench with disk/DRAM models
// and a transaction-queue scoreboard checked every cycle
module tb_dma_controller;

  localparam logic [31:0] KEEP = 32'h0;

  logic        CLK = 1'b0;
  logic        RST_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [31:0] cfg_wdata = 32'd0;
  logic        HLDA = 1'b0;
  wire  [31:0] dataBus;
  logic        HOLD, MEMR, MEMW, IOR, IOW, busy, done;
  logic [9:0]  addressBus_DRAM, addressBus_disk;

  logic [31:0] disk [0:1023];
  logic [31:0] dram [0:1023];

  typedef struct {
    int          kind;
    int          addr;
    logic [31:0] data;
  } ev_t;

  ev_t q[$];

  int checks = 0;
  int errors = 0;
  int strobes = 0;
  bit hold_seen = 1'b0;
  int cyc;

  dma_controller #(.ADDR_W(10), .DATA_W(32)) dut (
    .CLK            (CLK),
    .RST_n          (RST_n),
    .cfg_we         (cfg_we),
    .cfg_addr       (cfg_addr),
    .cfg_wdata      (cfg_wdata),
    .HOLD           (HOLD),
    .HLDA           (HLDA),
    .dataBus        (dataBus),
    .addressBus_DRAM(addressBus_DRAM),
    .MEMR           (MEMR),
    .MEMW           (MEMW),
    .addressBus_disk(addressBus_disk),
    .IOR            (IOR),
    .IOW            (IOW),
    .busy           (busy),
    .done           (done)
  );

  always #5 CLK = ~CLK;

  // devices answer reads; a keeper holds the bus when nobody drives
  assign dataBus = IOR ? disk[addressBus_disk]
                 : MEMR ? dram[addressBus_DRAM]
                 : (MEMW | IOW) ? 32'bz : KEEP;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic cfg_write(int a, int d);
    cfg_we    = 1'b1;
    cfg_addr  = a[1:0];
    cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  // model: each word is a source read then a destination write
  task automatic expect_xfer(int s, int d, int c, bit dr);
    int ra, wa;
    logic [31:0] v;
    for (int i = 0; i < c; i++) begin
      ra = (s + i) % 1024;
      wa = (d + i) % 1024;
      v  = dr ? dram[ra] : disk[ra];
      q.push_back('{dr ? 1 : 0, ra, v});
      q.push_back('{dr ? 3 : 2, wa, v});
    end
  endtask

  task automatic start_xfer(int s, int d, int c, bit dr);
    expect_xfer(s, d, c, dr);
    cfg_write(0, s);
    cfg_write(1, d);
    cfg_write(2, c);
    cfg_write(3, dr ? 3 : 1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      n++;
      if (done === 1'b1) break;
    end
    chk("done_seen", done, 1);
  endtask

  // per-cycle scoreboard and device write port
  always @(negedge CLK) begin
    int n, k;
    ev_t e;
    logic [31:0] a;
    if (RST_n) begin
      n = int'(IOR) + int'(IOW) + int'(MEMR) + int'(MEMW);
      if (HOLD) hold_seen = 1'b1;
      chk("one_strobe", n <= 1, 1);
      if (n == 0) begin
        chk("bus_idle", dataBus, KEEP);
      end else begin
        strobes++;
        chk("strobe_hold", HOLD, 1);
        k = IOR ? 0 : MEMR ? 1 : MEMW ? 2 : 3;
        a = (IOR | IOW) ? 32'(addressBus_disk)
                        : 32'(addressBus_DRAM);
        if (q.size() == 0) begin
          chk("strobe_extra", n, 0);
        end else begin
          e = q.pop_front();
          chk("strobe_kind", k, e.kind);
          chk("strobe_addr", a, e.addr);
          if (MEMW | IOW) chk("wr_data", dataBus, e.data);
        end
        if (MEMW) dram[addressBus_DRAM] = dataBus;
        if (IOW)  disk[addressBus_disk] = dataBus;
      end
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      disk[i] = 32'hD000_0000 + i;
      dram[i] = 32'hA000_0000 + i;
    end
    disk[5]    = 32'hAAAA_0001;
    disk[6]    = 32'hBBBB_0002;
    disk[7]    = 32'hCCCC_0003;
    dram[1022] = 32'h1111_1111;
    dram[1023] = 32'h2222_2222;
    dram[0]    = 32'h3333_3333;
    for (int i = 0; i < 4; i++) disk[200+i] = 32'hC0DE_0000 + i;

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_hold", HOLD, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_strb", {IOR, IOW, MEMR, MEMW}, 0);
    chk("rst_adram", addressBus_DRAM, 0);
    chk("rst_adisk", addressBus_disk, 0);
    chk("rst_bus", dataBus, KEEP);
    RST_n = 1'b1;
    tick();

    // disk->DRAM, grant two cycles after HOLD
    strobes = 0;
    start_xfer(5, 100, 3, 1'b0);
    chk("t1_hold", HOLD, 1);
    chk("t1_busy", busy, 1);
    tick();
    tick();
    chk("t1_wait", IOR, 0);
    HLDA = 1'b1;
    tick();
    chk("t1_rd_ior", IOR, 1);
    chk("t1_rd_addr", addressBus_disk, 5);
    wait_done(cyc);
    chk("t1_cycles", cyc, 6);
    chk("t1_hold_off", HOLD, 0);
    HLDA = 1'b0;
    tick();
    chk("t1_pulse", done, 0);
    chk("t1_idle", busy, 0);
    chk("t1_strobes", strobes, 6);
    chk("t1_m100", dram[100], 32'hAAAA_0001);
    chk("t1_m101", dram[101], 32'hBBBB_0002);
    chk("t1_m102", dram[102], 32'hCCCC_0003);
    chk("t1_left", q.size(), 0);

    // DRAM->disk with DRAM address wrap
    start_xfer(1022, 0, 3, 1'b1);
    HLDA = 1'b1;
    wait_done(cyc);
    chk("t2_cycles", cyc, 7);
    HLDA = 1'b0;
    tick();
    chk("t2_d0", disk[0], 32'h1111_1111);
    chk("t2_d1", disk[1], 32'h2222_2222);
    chk("t2_d2", disk[2], 32'h3333_3333);
    chk("t2_left", q.size(), 0);

    // zero count: immediate done, no bus activity
    strobes = 0;
    hold_seen = 1'b0;
    cfg_write(2, 0);
    cfg_write(3, 1);
    chk("t3_done", done, 1);
    chk("t3_hold", HOLD, 0);
    chk("t3_busy", busy, 0);
    tick();
    chk("t3_pulse", done, 0);
    tick();
    chk("t3_no_hold", hold_seen, 0);
    chk("t3_no_strb", strobes, 0);

    // grant dropped during RD of word 2 of 4
    start_xfer(200, 300, 4, 1'b0);
    HLDA = 1'b1;
    tick();
    tick();
    tick();
    chk("t4_rd2", IOR, 1);
    chk("t4_rd2_a", addressBus_disk, 201);
    HLDA = 1'b0;
    tick();
    chk("t4_wr2", MEMW, 1);
    chk("t4_wr2_a", addressBus_DRAM, 301);
    tick();
    chk("t4_park_h", HOLD, 1);
    chk("t4_park_s", {IOR, IOW, MEMR, MEMW}, 0);
    tick();
    tick();
    chk("t4_park_h2", HOLD, 1);
    chk("t4_park_b", busy, 1);
    HLDA = 1'b1;
    tick();
    chk("t4_rd3", IOR, 1);
    chk("t4_rd3_a", addressBus_disk, 202);
    wait_done(cyc);
    chk("t4_cycles", cyc, 4);
    HLDA = 1'b0;
    tick();
    for (int i = 0; i < 4; i++)
      chk("t4_mem", dram[300+i], 32'hC0DE_0000 + i);
    chk("t4_left", q.size(), 0);

    // reset during WR of word 1, then a clean transfer
    start_xfer(10, 400, 2, 1'b0);
    HLDA = 1'b1;
    tick();
    tick();
    chk("t5_wr1", MEMW, 1);
    #2;
    RST_n = 1'b0;
    #1;
    chk("t5_hold", HOLD, 0);
    chk("t5_strb", {IOR, IOW, MEMR, MEMW}, 0);
    chk("t5_busy", busy, 0);
    chk("t5_adram", addressBus_DRAM, 0);
    chk("t5_bus", dataBus, KEEP);
    q.delete();
    @(posedge CLK);
    #1;
    RST_n = 1'b1;
    HLDA = 1'b0;
    tick();
    start_xfer(5, 500, 3, 1'b0);
    HLDA = 1'b1;
    wait_done(cyc);
    chk("t5_cycles", cyc, 7);
    HLDA = 1'b0;
    tick();
    chk("t5_m500", dram[500], 32'hAAAA_0001);
    chk("t5_m501", dram[501], 32'hBBBB_0002);
    chk("t5_m502", dram[502], 32'hCCCC_0003);
    chk("t5_left", q.size(), 0);

    // SRC write while busy must be ignored
    start_xfer(600, 700, 2, 1'b1);
    cfg_write(0, 50);
    HLDA = 1'b1;
    tick();
    chk("t6_rd", MEMR, 1);
    chk("t6_rd_a", addressBus_DRAM, 600);
    wait_done(cyc);
    chk("t6_cycles", cyc, 4);
    HLDA = 1'b0;
    tick();
    chk("t6_d700", disk[700], 32'hA000_0258);
    chk("t6_d701", disk[701], 32'hA000_0259);
    chk("t6_left", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
